// File: rtl/mlspi_pkg.sv
// ---------------------------------------------------------------------------
// mlspi_pkg
// Shared definitions for the multi-lane SPI word receiver:
//   - mlspiState_e : receive FSM state encoding (RESYNC, IDLE, SHIFT)
//   - beatsPerWord : SCK beats needed to assemble one word
//   - beatCntWidth : width of a counter covering 0 .. beats-1
// No ports; imported by multi_lane_spi_rx and mlspi_sync_fifo.
// ---------------------------------------------------------------------------
package mlspi_pkg;

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SHIFT  = 2'd2
  } mlspiState_e;

  // Each SCK rising edge delivers one bit on every lane.
  function automatic int beatsPerWord(input int wordBits, input int lanes);
    return wordBits / lanes;
  endfunction

  // A single-beat word still needs a one-bit counter to stay a legal vector.
  function automatic int beatCntWidth(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mlspi_sync_fifo.sv
// ---------------------------------------------------------------------------
// mlspi_sync_fifo
// Single-clock show-ahead FIFO with occupancy output.
// Ports:
//   clk_i, rst_ni  : clock and synchronous active-low reset
//   push_i         : write request for wdata_i
//   pop_i          : pop request; ignored while empty
//   wdata_i        : word to write
//   rdata_o        : head word, valid whenever valid_o is high
//   valid_o        : FIFO non-empty
//   level_o        : current number of stored words
//   drop_o         : push refused because the FIFO was full with no pop
// Pointers carry one extra MSB so that full and empty can be told apart.
// ---------------------------------------------------------------------------
module mlspi_sync_fifo
  import mlspi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, doPush, doPop;

  // Work out which requests take effect this cycle. A pop in the same cycle
  // frees the slot, so a push into a full FIFO is accepted when it coincides
  // with a pop; only a push into a full FIFO without a pop is dropped.
  always_comb begin
    empty   = (wrPtr_q == rdPtr_q);
    full    = (wrPtr_q[AW] != rdPtr_q[AW]) &&
              (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    doPop   = pop_i && !empty;
    doPush  = push_i && (!full || doPop);
    drop_o  = push_i && full && !doPop;
    wrPtr_d = doPush ? (wrPtr_q + PTR_ONE) : wrPtr_q;
    rdPtr_d = doPop  ? (rdPtr_q + PTR_ONE) : rdPtr_q;
  end

  // Pointer registers; level is derived from them so it moves on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: nothing is read until a push has written it.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rdPtr_q[AW-1:0]];
  assign valid_o = !empty;
  assign level_o = wrPtr_q - rdPtr_q;

endmodule

// File: rtl/multi_lane_spi_rx.sv
// ---------------------------------------------------------------------------
// multi_lane_spi_rx
// Oversampling multi-lane SPI word receiver. SCK, CS and the data lanes are
// synchronized into synth_clk, words of WORD_BITS are assembled from LANES
// bits per SCK rising edge and pushed into a show-ahead FIFO.
// Ports:
//   synth_clk  : sole clock (>= 4x SCK)
//   rst_n      : synchronous active-low reset
//   sck_in     : asynchronous SPI clock, data taken on its rising edge
//   cs_in      : asynchronous active-low frame select
//   mosi_in    : LANES data lines, lane LANES-1 most significant per beat
//   read_data  : pop request for the head word
//   clr_err    : single-cycle clear of the sticky error flags
//   synth_data : head-of-FIFO word
//   data_valid : FIFO non-empty
//   busy       : synchronized frame-active indication
//   fifo_level : current FIFO occupancy
//   overflow   : sticky, a word was dropped on a full FIFO
//   frame_err  : sticky, CS rose with a partial word
//   err_count  : (only with MLSPI_ERR_CNT_EN) saturating error event count
// Optional feature macro: MLSPI_ERR_CNT_EN adds err_count.
// ---------------------------------------------------------------------------
module multi_lane_spi_rx
  import mlspi_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int WORD_BITS   = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          synth_clk,
  input  logic                          rst_n,
  input  logic                          sck_in,
  input  logic                          cs_in,
  input  logic [LANES-1:0]              mosi_in,
  input  logic                          read_data,
  input  logic                          clr_err,
  output logic [WORD_BITS-1:0]          synth_data,
  output logic                          data_valid,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err
`ifdef MLSPI_ERR_CNT_EN
  ,
  output logic [7:0]                    err_count
`endif
);

  localparam int BEATS  = beatsPerWord(WORD_BITS, LANES);
  localparam int BEAT_W = beatCntWidth(BEATS);
  localparam int SHW    = WORD_BITS - LANES;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sckSync_q;
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] csSync_q;
  (* ASYNC_REG = "TRUE" *) logic [LANES-1:0]       mosiSync_q [SYNC_STAGES];
  logic                   sckPrev_q;

  logic                   sckRise, csHigh;
  logic [LANES-1:0]       mosiSync;

  mlspiState_e            state_q, state_d;
  logic [SHW-1:0]         shreg_q, shreg_d;
  logic [BEAT_W-1:0]      beatCnt_q, beatCnt_d;
  logic [WORD_BITS-1:0]   assembled;
  logic                   pushReq, frameErrEv, fifoDrop;
  logic                   busy_q, overflow_q, overflow_d, frameErr_q, frameErr_d;

`ifdef MLSPI_ERR_CNT_EN
  logic [7:0]             errCnt_q, errCnt_d;
  logic [8:0]             errSum;
`endif

  // Input synchronizers. These only track the pins, so they are not reset:
  // right after reset the FSM must see the true CS level to decide whether
  // a frame is already in progress.
  always_ff @(posedge synth_clk) begin
    sckSync_q     <= {sckSync_q[SYNC_STAGES-2:0], sck_in};
    csSync_q      <= {csSync_q[SYNC_STAGES-2:0], cs_in};
    mosiSync_q[0] <= mosi_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosiSync_q[i] <= mosiSync_q[i-1];
    end
    sckPrev_q     <= sckSync_q[SYNC_STAGES-1];
  end

  assign sckRise   = sckSync_q[SYNC_STAGES-1] & ~sckPrev_q;
  assign csHigh    = csSync_q[SYNC_STAGES-1];
  assign mosiSync  = mosiSync_q[SYNC_STAGES-1];
  assign assembled = {shreg_q, mosiSync};

  // Receive FSM. RESYNC refuses to join a frame already running at reset.
  // In SHIFT a CS release takes priority over a coincident SCK edge, so that
  // beat is lost and any partial word is reported as a framing error.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    beatCnt_d  = beatCnt_q;
    pushReq    = 1'b0;
    frameErrEv = 1'b0;
    unique case (state_q)
      ST_RESYNC: begin
        if (csHigh) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        beatCnt_d = '0;
        if (!csHigh) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (csHigh) begin
          state_d    = ST_IDLE;
          frameErrEv = (beatCnt_q != '0);
          beatCnt_d  = '0;
        end else if (sckRise) begin
          shreg_d = assembled[SHW-1:0];
          if (beatCnt_q == BEAT_LAST) begin
            pushReq   = 1'b1;
            beatCnt_d = '0;
          end else begin
            beatCnt_d = beatCnt_q + BEAT_ONE;
          end
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  // Sticky flags: clr_err clears them, but a new event in the same cycle wins.
  always_comb begin
    overflow_d = (clr_err ? 1'b0 : overflow_q) | fifoDrop;
    frameErr_d = (clr_err ? 1'b0 : frameErr_q) | frameErrEv;
  end

`ifdef MLSPI_ERR_CNT_EN
  // Error event counter, saturating at 255; events coinciding with clr_err
  // are counted from zero.
  always_comb begin
    errSum   = {1'b0, (clr_err ? 8'd0 : errCnt_q)}
             + {8'd0, fifoDrop} + {8'd0, frameErrEv};
    errCnt_d = errSum[8] ? 8'hFF : errSum[7:0];
  end
`else
  // Without the counter the sticky flags are the only error report.
`endif

  // State, datapath and flag registers.
  always_ff @(posedge synth_clk) begin
    if (!rst_n) begin
      state_q    <= ST_RESYNC;
      shreg_q    <= '0;
      beatCnt_q  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      frameErr_q <= 1'b0;
`ifdef MLSPI_ERR_CNT_EN
      errCnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      beatCnt_q  <= beatCnt_d;
      busy_q     <= ~csHigh;
      overflow_q <= overflow_d;
      frameErr_q <= frameErr_d;
`ifdef MLSPI_ERR_CNT_EN
      errCnt_q   <= errCnt_d;
`endif
    end
  end

  mlspi_sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (synth_clk),
    .rst_ni  (rst_n),
    .push_i  (pushReq),
    .pop_i   (read_data),
    .wdata_i (assembled),
    .rdata_o (synth_data),
    .valid_o (data_valid),
    .level_o (fifo_level),
    .drop_o  (fifoDrop)
  );

  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign frame_err = frameErr_q;
`ifdef MLSPI_ERR_CNT_EN
  assign err_count = errCnt_q;
`endif

endmodule

// File: tb/tb_multi_lane_spi_rx.sv
// ---------------------------------------------------------------------------
// tb_multi_lane_spi_rx
// Randomized bench for multi_lane_spi_rx with a scoreboard. Words are sent as
// SPI beats; the reference model tracks expected FIFO contents as a queue of
// whole words and the expected error flags, and a monitor process pops the
// DUT and compares each head word against the queue.
// Optional feature macro: MLSPI_ERR_CNT_EN enables err_count checks.
// ---------------------------------------------------------------------------
module tb_multi_lane_spi_rx;

  localparam int LANES       = 2;
  localparam int WORD_BITS   = 32;
  localparam int FIFO_DEPTH  = 16;
  localparam int SYNC_STAGES = 2;
  localparam int BPW         = WORD_BITS / LANES;

  logic                        synth_clk;
  logic                        rst_n;
  logic                        sck_in;
  logic                        cs_in;
  logic [LANES-1:0]            mosi_in;
  logic                        read_data;
  logic                        clr_err;
  logic [WORD_BITS-1:0]        synth_data;
  logic                        data_valid;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        overflow;
  logic                        frame_err;
`ifdef MLSPI_ERR_CNT_EN
  logic [7:0]                  err_count;
`endif

  // Reference model state
  logic [WORD_BITS-1:0] expQ[$];
  bit                   expOverflow;
  bit                   expFrameErr;
  int                   expErrCnt;
  bit                   modelArmed;
  int                   modelBeat;

  bit autoRead;
  bit manualRead;
  int nChecks;
  int nPass;

  multi_lane_spi_rx #(
    .LANES       (LANES),
    .WORD_BITS   (WORD_BITS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .synth_clk  (synth_clk),
    .rst_n      (rst_n),
    .sck_in     (sck_in),
    .cs_in      (cs_in),
    .mosi_in    (mosi_in),
    .read_data  (read_data),
    .clr_err    (clr_err),
    .synth_data (synth_data),
    .data_valid (data_valid),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err)
`ifdef MLSPI_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  // 100 MHz-style clock; SCK is generated at synth_clk/8.
  initial synth_clk = 1'b0;
  always #5 synth_clk = ~synth_clk;

  // Global time bound so the bench always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual === expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance n rising edges, then settle away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge synth_clk);
    #2;
  endtask

  task automatic bumpErr();
    if (expErrCnt < 255) expErrCnt++;
  endtask

  // A complete word enters the model FIFO, unless it is full and no pop is
  // scheduled to coincide with it.
  task automatic modelPush(input logic [WORD_BITS-1:0] w, input bit coincident);
    if (modelArmed) begin
      if (expQ.size() < FIFO_DEPTH || coincident) begin
        expQ.push_back(w);
      end else begin
        expOverflow = 1'b1;
        bumpErr();
      end
    end
  endtask

  // One SCK period: data changes while SCK is low, SCK then rises.
  // With coincident set, a single-cycle read is timed to land on the same
  // edge as the resulting push (sync stages plus edge detect after the rise).
  task automatic sendBeat(input logic [LANES-1:0] d, input bit coincident);
    sck_in  = 1'b0;
    mosi_in = d;
    tick(4);
    sck_in = 1'b1;
    if (coincident) begin
      @(posedge synth_clk);
      @(posedge synth_clk);
      #1 manualRead = 1'b1;
      @(posedge synth_clk);
      #1 manualRead = 1'b0;
      @(posedge synth_clk);
      #2;
    end else begin
      tick(4);
    end
    if (modelArmed) modelBeat++;
  endtask

  task automatic sendWord(input logic [WORD_BITS-1:0] w, input bit coincident);
    logic [LANES-1:0] d;
    for (int k = 0; k < BPW; k++) begin
      d = w[WORD_BITS-1-k*LANES -: LANES];
      if (k == BPW - 1) modelPush(w, coincident);
      sendBeat(d, coincident && (k == BPW - 1));
    end
  endtask

  task automatic startFrame();
    sck_in = 1'b0;
    cs_in  = 1'b0;
    modelBeat = 0;
    tick(4);
  endtask

  task automatic endFrame();
    sck_in = 1'b0;
    tick(4);
    cs_in = 1'b1;
    if (modelArmed && (modelBeat % BPW) != 0) begin
      expFrameErr = 1'b1;
      bumpErr();
    end
    modelArmed = 1'b1;
    modelBeat  = 0;
    tick(8);
  endtask

  // One frame of random whole words followed by optional stray beats.
  task automatic applyStimulus(input int nWords, input int extraBeats,
                               input bit coincidentLast);
    logic [WORD_BITS-1:0] w;
    logic [LANES-1:0]     d;
    startFrame();
    for (int i = 0; i < nWords; i++) begin
      w = $urandom;
      sendWord(w, coincidentLast && (i == nWords - 1));
    end
    for (int i = 0; i < extraBeats; i++) begin
      d = LANES'($urandom_range(0, (1 << LANES) - 1));
      sendBeat(d, 1'b0);
    end
    endFrame();
  endtask

  task automatic applyReset(input bit doCheck);
    autoRead = 1'b0;
    rst_n = 1'b0;
    tick(3);
    if (doCheck) begin
      checkOutput("rst_data_valid", 64'(data_valid), 64'd0);
      checkOutput("rst_busy",       64'(busy),       64'd0);
      checkOutput("rst_fifo_level", 64'(fifo_level), 64'd0);
      checkOutput("rst_overflow",   64'(overflow),   64'd0);
      checkOutput("rst_frame_err",  64'(frame_err),  64'd0);
`ifdef MLSPI_ERR_CNT_EN
      checkOutput("rst_err_count",  64'(err_count),  64'd0);
`endif
    end
    expQ.delete();
    expOverflow = 1'b0;
    expFrameErr = 1'b0;
    expErrCnt   = 0;
    modelBeat   = 0;
    modelArmed  = cs_in;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic clearErr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    expOverflow = 1'b0;
    expFrameErr = 1'b0;
    expErrCnt   = 0;
    tick(1);
  endtask

  task automatic checkFlags(input string tag);
    checkOutput({tag, "_overflow"},  64'(overflow),  64'(expOverflow));
    checkOutput({tag, "_frame_err"}, 64'(frame_err), 64'(expFrameErr));
`ifdef MLSPI_ERR_CNT_EN
    checkOutput({tag, "_err_count"}, 64'(err_count), 64'(expErrCnt));
`endif
  endtask

  // Let the monitor empty the FIFO, bounded in cycles.
  task automatic drain(input string tag);
    autoRead = 1'b1;
    for (int i = 0; i < 500 && expQ.size() != 0; i++) tick(1);
    tick(4);
    checkOutput({tag, "_model_empty"}, 64'(expQ.size()), 64'd0);
    checkOutput({tag, "_level"},       64'(fifo_level),  64'd0);
    checkOutput({tag, "_valid"},       64'(data_valid),  64'd0);
  endtask

  // Monitor: decides the read each cycle and compares every popped word
  // against the front of the expected queue.
  initial begin : monitor
    logic [WORD_BITS-1:0] expWord;
    bit rd;
    read_data = 1'b0;
    forever begin
      @(negedge synth_clk);
      rd = autoRead ? data_valid : manualRead;
      read_data = rd;
      if (rd && data_valid) begin
        checkOutput("pop_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          expWord = expQ.pop_front();
          checkOutput("pop_data", 64'(synth_data), 64'(expWord));
        end
      end
    end
  end

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst_n = 1'b1;
    cs_in = 1'b1;
    sck_in = 1'b0;
    mosi_in = '0;
    clr_err = 1'b0;
    autoRead = 1'b0;
    manualRead = 1'b0;
    expOverflow = 1'b0;
    expFrameErr = 1'b0;
    expErrCnt = 0;
    modelArmed = 1'b0;
    modelBeat = 0;
    tick(4);

    $display("[TB] reset");
    applyReset(1'b1);

    $display("[TB] single known word");
    startFrame();
    checkOutput("busy_in_frame", 64'(busy), 64'd1);
    sendWord(32'hDEADBEEF, 1'b0);
    endFrame();
    checkOutput("known_level",  64'(fifo_level), 64'(expQ.size()));
    checkOutput("known_valid",  64'(data_valid), 64'd1);
    checkOutput("known_data",   64'(synth_data), 64'hDEADBEEF);
    checkOutput("busy_idle",    64'(busy),       64'd0);
    drain("known");

    $display("[TB] random frames");
    autoRead = 1'b1;
    for (int f = 0; f < 6; f++) begin
      applyStimulus($urandom_range(1, 3), 0, 1'b0);
    end
    drain("random");
    checkFlags("random");

    $display("[TB] framing error");
    applyStimulus(0, 5, 1'b0);
    checkFlags("ferr_set");
    applyStimulus(1, 0, 1'b0);
    drain("ferr_next");
    checkFlags("ferr_hold");
    clearErr();
    checkFlags("ferr_clr");

    $display("[TB] overflow");
    autoRead = 1'b0;
    applyStimulus(FIFO_DEPTH + 1, 0, 1'b0);
    checkOutput("ovf_level", 64'(fifo_level), 64'(expQ.size()));
    checkFlags("ovf_set");
    clearErr();
    checkFlags("ovf_clr");

    $display("[TB] push coinciding with pop on full FIFO");
    applyStimulus(1, 0, 1'b1);
    checkOutput("coin_level", 64'(fifo_level), 64'(expQ.size()));
    checkFlags("coin");
    drain("coin");

    $display("[TB] reset mid-frame");
    autoRead = 1'b1;
    startFrame();
    for (int i = 0; i < 7; i++) sendBeat(LANES'($urandom_range(0, 3)), 1'b0);
    applyReset(1'b0);
    sendWord($urandom, 1'b0);
    checkOutput("midrst_level", 64'(fifo_level), 64'(expQ.size()));
    checkOutput("midrst_valid", 64'(data_valid), 64'd0);
    endFrame();
    checkFlags("midrst");
    applyStimulus(2, 0, 1'b0);
    drain("midrst_next");
    checkFlags("final");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
